// File: rtl/uart_fifo_sched_if.sv
// Bundle of the UART TX FIFO scheduler's bus signals: the two write requesters,
// the FIFO port and the transmitter handshake.
interface uart_fifo_sched_if #(
    parameter int DATA_SIZE = 8
);
    logic                 req_a;
    logic                 req_b;
    logic [DATA_SIZE-1:0] data_a;
    logic [DATA_SIZE-1:0] data_b;
    logic                 ack_a;
    logic                 ack_b;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_SIZE-1:0] fifo_r_data;
    logic                 fifo_wr;
    logic                 fifo_rd;
    logic [DATA_SIZE-1:0] fifo_w_data;

    logic                 tx_busy;
    logic                 tx_done;
    logic                 tx_start;
    logic [DATA_SIZE-1:0] tx_data;

    // Scheduler side
    modport master (
        input  req_a, req_b, data_a, data_b,
        input  fifo_full, fifo_empty, fifo_r_data,
        input  tx_busy, tx_done,
        output ack_a, ack_b, fifo_wr, fifo_rd, fifo_w_data,
        output tx_start, tx_data
    );

    // Requesters, FIFO and transmitter side
    modport slave (
        output req_a, req_b, data_a, data_b,
        output fifo_full, fifo_empty, fifo_r_data,
        output tx_busy, tx_done,
        input  ack_a, ack_b, fifo_wr, fifo_rd, fifo_w_data,
        input  tx_start, tx_data
    );
endinterface

// File: rtl/uart_fifo_sched.sv
// UART TX FIFO scheduler: round-robin write arbitration between two requesters,
// a stalled-write counter, and a drain FSM that feeds the transmitter one byte
// at a time under a completion watchdog. Every FIFO strobe is qualified by
// s_tick and by the FIFO flags because the FIFO itself does not check them.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a tick with data available and the transmitter free
// START | byte popped last edge; tx_start pulses, watchdog cleared
// WAIT  | transmitter running; watchdog counts ticks until tx_done
module uart_fifo_sched #(
    parameter int DATA_SIZE = 8,
    parameter int TIMEOUT   = 4096,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_tick_i,
    input  logic                 drain_en_i,
    input  logic                 timeout_clr_i,
    output logic                 tx_timeout_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    uart_fifo_sched_if.master    bus
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 rr_q, rr_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [CNT_W-1:0]     stall_q, stall_d;
    logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
    logic                 tx_timeout_q, tx_timeout_d;
    logic                 to_set;

    logic any_req;
    logic sel_b;
    logic wr_ok;

    // rr_q = 1 gives B priority when both sides request
    assign any_req = bus.req_a | bus.req_b;
    assign sel_b   = bus.req_b & (~bus.req_a | rr_q);
    assign wr_ok   = s_tick_i & ~bus.fifo_full & any_req;

    assign bus.fifo_wr     = wr_ok;
    assign bus.ack_a       = wr_ok & ~sel_b;
    assign bus.ack_b       = wr_ok & sel_b;
    assign bus.fifo_w_data = sel_b ? bus.data_b : bus.data_a;
    assign bus.tx_data     = tx_data_q;
    assign tx_timeout_o    = tx_timeout_q;
    assign stall_cnt_o     = stall_q;

    // Arbitration pointer moves to the loser; stall counter saturates
    always_comb begin
        rr_d    = rr_q;
        stall_d = stall_q;
        if (wr_ok) begin
            rr_d = ~sel_b;
        end
        if (s_tick_i && bus.fifo_full && any_req && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Drain FSM next state, pop strobe, start pulse and watchdog
    always_comb begin
        state_d      = state_q;
        wd_d         = wd_q;
        tx_data_d    = tx_data_q;
        to_set       = 1'b0;
        bus.fifo_rd  = 1'b0;
        bus.tx_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // tx_start is always low here; the pop is one-per-transfer by construction
                if (s_tick_i && drain_en_i && !bus.fifo_empty && !bus.tx_busy) begin
                    bus.fifo_rd = 1'b1;
                    tx_data_d   = bus.fifo_r_data;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                bus.tx_start = 1'b1;
                wd_d         = '0;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                // completion beats an expiry landing in the same cycle
                if (bus.tx_done) begin
                    state_d = ST_IDLE;
                end else if (s_tick_i) begin
                    if (wd_q == WD_LAST) begin
                        to_set  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        tx_timeout_d = to_set | (tx_timeout_q & ~timeout_clr_i);
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            wd_q         <= '0;
            stall_q      <= '0;
            tx_data_q    <= '0;
            tx_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            wd_q         <= wd_d;
            stall_q      <= stall_d;
            tx_data_q    <= tx_data_d;
            tx_timeout_q <= tx_timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_fifo_sched.sv
// Bench for uart_fifo_sched: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_uart_fifo_sched;

    localparam int DW = 8;
    localparam int TO = 8;
    localparam int CW = 4;
    localparam int STALL_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_tick = 1'b0;
    logic          drain_en = 1'b1;
    logic          timeout_clr = 1'b0;
    logic          tx_timeout;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    uart_fifo_sched_if #(.DATA_SIZE(DW)) bus ();

    uart_fifo_sched #(
        .DATA_SIZE(DW),
        .TIMEOUT  (TO),
        .CNT_W    (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick_i     (s_tick),
        .drain_en_i   (drain_en),
        .timeout_clr_i(timeout_clr),
        .tx_timeout_o (tx_timeout),
        .stall_cnt_o  (stall_cnt),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    // Reference model: who is owed priority, stalled ticks seen, and where the
    // current transfer stands (start owed, awaiting done, ticks spent waiting)
    bit            m_pref_b;
    int            m_stall;
    bit            m_start_due;
    bit            m_await;
    int            m_ticks;
    logic [DW-1:0] m_txdata;
    bit            m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pref_b    = 1'b0;
        m_stall     = 0;
        m_start_due = 1'b0;
        m_await     = 1'b0;
        m_ticks     = 0;
        m_txdata    = '0;
        m_to        = 1'b0;
    endtask

    // One clock: compare at negedge, advance the model, return just after posedge
    task automatic cyc();
        bit any, win_b, e_wr, e_rd, fire;
        @(negedge clk);
        any   = bus.req_a | bus.req_b;
        win_b = bus.req_b && (!bus.req_a || m_pref_b);
        e_wr  = s_tick && !bus.fifo_full && any;
        e_rd  = s_tick && drain_en && !bus.fifo_empty && !bus.tx_busy && !m_start_due && !m_await;
        chk("fifo_wr",    32'(bus.fifo_wr),  32'(e_wr));
        chk("ack_a",      32'(bus.ack_a),    32'(e_wr && !win_b));
        chk("ack_b",      32'(bus.ack_b),    32'(e_wr && win_b));
        if (e_wr) chk("fifo_w_data", 32'(bus.fifo_w_data), 32'(win_b ? bus.data_b : bus.data_a));
        chk("fifo_rd",    32'(bus.fifo_rd),  32'(e_rd));
        chk("tx_start",   32'(bus.tx_start), 32'(m_start_due));
        chk("tx_data",    32'(bus.tx_data),  32'(m_txdata));
        chk("tx_timeout", 32'(tx_timeout),   32'(m_to));
        chk("stall_cnt",  32'(stall_cnt),    32'(m_stall));

        fire = 1'b0;
        if (e_wr) m_pref_b = !win_b;
        if (s_tick && bus.fifo_full && any && m_stall < STALL_MAX) m_stall++;
        if (m_start_due) begin
            m_start_due = 1'b0;
            m_await     = 1'b1;
            m_ticks     = 0;
        end else if (m_await) begin
            if (bus.tx_done) begin
                m_await = 1'b0;
            end else if (s_tick) begin
                m_ticks++;
                if (m_ticks == TO) begin
                    fire    = 1'b1;
                    m_await = 1'b0;
                end
            end
        end
        if (e_rd) begin
            m_start_due = 1'b1;
            m_txdata    = bus.fifo_r_data;
        end
        if (fire) m_to = 1'b1;
        else if (timeout_clr) m_to = 1'b0;

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_tx_start",   32'(bus.tx_start), 32'd0);
        chk("rst_tx_timeout", 32'(tx_timeout),   32'd0);
        chk("rst_stall_cnt",  32'(stall_cnt),    32'd0);
        chk("rst_tx_data",    32'(bus.tx_data),  32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.req_a       = 1'b0;
        bus.req_b       = 1'b0;
        bus.data_a      = '0;
        bus.data_b      = '0;
        bus.fifo_full   = 1'b0;
        bus.fifo_empty  = 1'b1;
        bus.fifo_r_data = '0;
        bus.tx_busy     = 1'b0;
        bus.tx_done     = 1'b0;
        model_reset();
        do_reset();

        // A writes 0x5A with ticks every 4 clocks, then the byte is drained
        bus.req_a  = 1'b1;
        bus.data_a = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            s_tick = (i == 3);
            if (i == 3) begin
                #2;
                chk("a_first_ack",   32'(bus.ack_a),       32'd1);
                chk("a_first_wdata", 32'(bus.fifo_w_data), 32'h5A);
            end
            cyc();
        end
        bus.req_a       = 1'b0;
        bus.fifo_empty  = 1'b0;
        bus.fifo_r_data = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            s_tick = (i == 3);
            if (i == 3) begin
                #2;
                chk("a_pop", 32'(bus.fifo_rd), 32'd1);
            end
            cyc();
        end
        s_tick         = 1'b0;
        bus.fifo_empty = 1'b1;
        #2;
        chk("a_tx_start", 32'(bus.tx_start), 32'd1);
        chk("a_tx_data",  32'(bus.tx_data),  32'h5A);
        cyc();
        #2;
        chk("a_start_one_clk", 32'(bus.tx_start), 32'd0);
        cyc();
        bus.tx_done = 1'b1;
        cyc();
        bus.tx_done = 1'b0;
        cyc();

        // Contention: strict alternation starting with A after reset
        do_reset();
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b1;
        bus.data_a = 8'hA1;
        bus.data_b = 8'hB2;
        s_tick     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            chk("rr_ack_a", 32'(bus.ack_a), 32'(i % 2 == 0));
            chk("rr_ack_b", 32'(bus.ack_b), 32'(i % 2 == 1));
            cyc();
        end
        bus.req_a = 1'b0;

        // Full FIFO stalls B for 5 ticks, then releases
        do_reset();
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        #2;
        chk("full_stall5", 32'(stall_cnt), 32'd5);
        bus.fifo_full = 1'b0;
        #2;
        chk("full_release_ack", 32'(bus.ack_b), 32'd1);
        cyc();
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 14; i++) cyc();
        #2;
        chk("stall_saturate", 32'(stall_cnt), 32'(STALL_MAX));
        bus.fifo_full = 1'b0;
        bus.req_b     = 1'b0;
        cyc();

        // Simultaneous write and read on one tick
        do_reset();
        bus.fifo_empty  = 1'b0;
        bus.fifo_r_data = 8'h33;
        bus.req_a       = 1'b1;
        bus.data_a      = 8'h44;
        s_tick          = 1'b1;
        #2;
        chk("rw_wr", 32'(bus.fifo_wr), 32'd1);
        chk("rw_rd", 32'(bus.fifo_rd), 32'd1);
        cyc();

        // Watchdog with no tx_done: fires on the 8th tick in WAIT
        bus.req_a      = 1'b0;
        bus.fifo_empty = 1'b1;
        cyc();
        for (int i = 0; i < 7; i++) cyc();
        #2;
        chk("wd_not_yet", 32'(tx_timeout), 32'd0);
        cyc();
        #2;
        chk("wd_fired", 32'(tx_timeout), 32'd1);
        bus.req_a = 1'b1;
        #2;
        chk("empty_no_rd", 32'(bus.fifo_rd), 32'd0);
        cyc();
        bus.req_a       = 1'b0;
        bus.fifo_empty  = 1'b0;
        bus.fifo_r_data = 8'h77;
        timeout_clr     = 1'b1;
        #2;
        chk("idle_after_wd", 32'(bus.fifo_rd), 32'd1);
        cyc();
        timeout_clr = 1'b0;
        #2;
        chk("wd_cleared", 32'(tx_timeout), 32'd0);
        bus.fifo_empty = 1'b1;
        cyc();
        for (int i = 0; i < 7; i++) cyc();
        bus.tx_done = 1'b1;
        cyc();
        bus.tx_done = 1'b0;
        #2;
        chk("done_beats_expiry", 32'(tx_timeout), 32'd0);

        // Set the flag again, then reset from WAIT with stalls accumulating
        bus.fifo_empty = 1'b0;
        cyc();
        bus.fifo_empty = 1'b1;
        for (int i = 0; i < 9; i++) cyc();
        #2;
        chk("wd_fired_again", 32'(tx_timeout), 32'd1);
        bus.fifo_empty  = 1'b0;
        bus.fifo_r_data = 8'h12;
        cyc();
        bus.fifo_empty = 1'b1;
        bus.fifo_full  = 1'b1;
        bus.req_b      = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        reset_n = 1'b0;
        #1;
        chk("rst_wait_timeout", 32'(tx_timeout), 32'd0);
        chk("rst_wait_stall",   32'(stall_cnt),  32'd0);
        chk("rst_wait_start",   32'(bus.tx_start), 32'd0);
        model_reset();
        reset_n        = 1'b1;
        bus.fifo_full  = 1'b0;
        bus.req_b      = 1'b0;
        bus.fifo_empty = 1'b0;
        #2;
        chk("rst_wait_idle_pop", 32'(bus.fifo_rd), 32'd1);
        cyc();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            s_tick          = ($urandom_range(0, 2) == 0);
            drain_en        = ($urandom_range(0, 7) != 0);
            timeout_clr     = ($urandom_range(0, 15) == 0);
            bus.req_a       = 1'($urandom_range(0, 1));
            bus.req_b       = 1'($urandom_range(0, 1));
            bus.data_a      = DW'($urandom);
            bus.data_b      = DW'($urandom);
            bus.fifo_full   = ($urandom_range(0, 4) == 0);
            bus.fifo_empty  = ($urandom_range(0, 3) == 0);
            bus.fifo_r_data = DW'($urandom);
            bus.tx_busy     = ($urandom_range(0, 5) == 0);
            bus.tx_done     = ($urandom_range(0, 39) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
